id_ex_pipeline_reg: RTL and testbench

// - ID->EX pipeline register plus load-use hazard control for the 5-stage MIPS pipeline.
// - Captures register-file read data, sign-extended immediate, register indices and decoded

---
 rtl/mips_pkg.sv | 23 ++
 rtl/id_ex_pipeline_reg_if.sv | 37 +++
 rtl/id_ex_pipeline_reg_load_use_detect.sv | 14 +
 rtl/id_ex_pipeline_reg.sv | 57 +++++
 tb/tb_id_ex_pipeline_reg.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared control types and constants for the MIPS pipeline
package mips_pkg;
  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_t;
  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    logic    branch;
    alu_op_t alu_op;
  } ctrl_t;
  typedef enum logic {RUN, STALL} hz_state_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// id_ex_pipeline_reg_if: ID-side inputs, EX-side outputs and stall controls of the ID/EX register
interface id_ex_pipeline_reg_if import mips_pkg::*; #(parameter int XLEN = 32) ();
  logic            id_valid;
  logic [XLEN-1:0] id_pc_plus4;
  logic [XLEN-1:0] id_rdata1;
  logic [XLEN-1:0] id_rdata2;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic [4:0]      id_rd;
  logic            id_uses_rt;
  ctrl_t           id_ctrl;
  logic            flush_ex;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc_plus4;
  logic [XLEN-1:0] ex_rdata1;
  logic [XLEN-1:0] ex_rdata2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs;
  logic [4:0]      ex_rt;
  logic [4:0]      ex_rd;
  ctrl_t           ex_ctrl;
  logic            stall_pc;
  logic            stall_ifid;
  modport master (
    output id_valid, id_pc_plus4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd,
           id_uses_rt, id_ctrl, flush_ex,
    input  ex_valid, ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_ctrl, stall_pc, stall_ifid
  );
  modport slave (
    input  id_valid, id_pc_plus4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd,
           id_uses_rt, id_ctrl, flush_ex,
    output ex_valid, ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_ctrl, stall_pc, stall_ifid
  );
endinterface

// File: rtl/id_ex_pipeline_reg_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load sitting in EX
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hz
);
  assign hz = ex_valid & ex_mem_read & (ex_rt != 5'd0) & id_valid &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID->EX pipeline register with load-use stall FSM and branch flush
module id_ex_pipeline_reg import mips_pkg::*; #(
  parameter int STALL_CYCLES = 1,
  parameter int XLEN         = 32
) (
  input logic clk,
  input logic reset,
  id_ex_pipeline_reg_if.slave bus
);
  hz_state_t  state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       hz, cap, keep;
  load_use_detect u_det (
    .ex_valid   (bus.ex_valid),
    .ex_mem_read(bus.ex_ctrl.mem_read),
    .ex_rt      (bus.ex_rt),
    .id_valid   (bus.id_valid),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .hz         (hz)
  );
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    if (bus.flush_ex) begin
      state_n = RUN;
      cnt_n   = '0;
    end else if (state == STALL) begin
      cnt_n   = cnt - 3'd1;
      state_n = (cnt == 3'd1) ? RUN : STALL;
    end else if (hz) begin
      state_n = (STALL_CYCLES > 1) ? STALL : RUN;
      cnt_n   = (STALL_CYCLES > 1) ? 3'(STALL_CYCLES - 1) : '0;
    end else begin
      cap = 1'b1;
    end
  end
  // Anything other than a clean capture in RUN loads a bubble.
  assign keep           = cap & ~reset;
  assign bus.stall_pc   = ~reset & ~bus.flush_ex & ((state == STALL) | hz);
  assign bus.stall_ifid = bus.stall_pc;
  always_ff @(posedge clk) begin
    state           <= reset ? RUN : state_n;
    cnt             <= reset ? 3'd0 : cnt_n;
    bus.ex_valid    <= keep & bus.id_valid;
    bus.ex_ctrl     <= (keep & bus.id_valid) ? bus.id_ctrl : CTRL_BUBBLE;
    bus.ex_pc_plus4 <= keep ? bus.id_pc_plus4 : {XLEN{1'b0}};
    bus.ex_rdata1   <= keep ? bus.id_rdata1 : {XLEN{1'b0}};
    bus.ex_rdata2   <= keep ? bus.id_rdata2 : {XLEN{1'b0}};
    bus.ex_imm      <= keep ? bus.id_imm : {XLEN{1'b0}};
    bus.ex_rs       <= keep ? bus.id_rs : 5'd0;
    bus.ex_rt       <= keep ? bus.id_rt : 5'd0;
    bus.ex_rd       <= keep ? bus.id_rd : 5'd0;
  end
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: directed scoreboard bench for single- and triple-bubble configurations
module tb_id_ex_pipeline_reg;
  import mips_pkg::*;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } exp_t;
  localparam ctrl_t C_ADD = ctrl_t'(11'b1000010_0010);
  localparam ctrl_t C_LW  = ctrl_t'(11'b1110100_0010);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  int checks = 0;
  int errors = 0;
  int n = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  id_ex_pipeline_reg_if #(.XLEN(32)) b1 ();
  id_ex_pipeline_reg_if #(.XLEN(32)) b3 ();
  id_ex_pipeline_reg #(.STALL_CYCLES(1), .XLEN(32)) d1 (.clk(clk), .reset(reset), .bus(b1));
  id_ex_pipeline_reg #(.STALL_CYCLES(3), .XLEN(32)) d3 (.clk(clk), .reset(reset), .bus(b3));
  assign b3.id_valid    = b1.id_valid;
  assign b3.id_pc_plus4 = b1.id_pc_plus4;
  assign b3.id_rdata1   = b1.id_rdata1;
  assign b3.id_rdata2   = b1.id_rdata2;
  assign b3.id_imm      = b1.id_imm;
  assign b3.id_rs       = b1.id_rs;
  assign b3.id_rt       = b1.id_rt;
  assign b3.id_rd       = b1.id_rd;
  assign b3.id_uses_rt  = b1.id_uses_rt;
  assign b3.id_ctrl     = b1.id_ctrl;
  assign b3.flush_ex    = b1.flush_ex;

  function automatic exp_t obs();
    exp_t o;
    o.valid = sel ? b3.ex_valid : b1.ex_valid;
    o.pc    = sel ? b3.ex_pc_plus4 : b1.ex_pc_plus4;
    o.a     = sel ? b3.ex_rdata1 : b1.ex_rdata1;
    o.b     = sel ? b3.ex_rdata2 : b1.ex_rdata2;
    o.imm   = sel ? b3.ex_imm : b1.ex_imm;
    o.rs    = sel ? b3.ex_rs : b1.ex_rs;
    o.rt    = sel ? b3.ex_rt : b1.ex_rt;
    o.rd    = sel ? b3.ex_rd : b1.ex_rd;
    o.ctrl  = sel ? b3.ex_ctrl : b1.ex_ctrl;
    return o;
  endfunction

  task automatic step(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic ur, input ctrl_t c, input logic f,
                      input logic [31:0] a, input logic cap, input logic st);
    exp_t e;
    exp_t o;
    logic [1:0] so;
    @(negedge clk);
    reset          = r;
    b1.id_valid    = v;
    b1.id_pc_plus4 = $urandom;
    b1.id_rdata1   = a;
    b1.id_rdata2   = $urandom;
    b1.id_imm      = $urandom;
    b1.id_rs       = rs;
    b1.id_rt       = rt;
    b1.id_rd       = rd;
    b1.id_uses_rt  = ur;
    b1.id_ctrl     = c;
    b1.flush_ex    = f;
    #1;
    so = sel ? {b3.stall_pc, b3.stall_ifid} : {b1.stall_pc, b1.stall_ifid};
    checks++;
    assert (so === {st, st}) else begin
      errors++;
      $error("FAIL stall step %0d dut%0d observed %b expected %b", n, sel ? 3 : 1, so, {st, st});
    end
    e = '0;
    if (cap) begin
      e.valid = v;
      e.pc    = b1.id_pc_plus4;
      e.a     = a;
      e.b     = b1.id_rdata2;
      e.imm   = b1.id_imm;
      e.rs    = rs;
      e.rt    = rt;
      e.rd    = rd;
      e.ctrl  = v ? c : CTRL_BUBBLE;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL ex_regs step %0d dut%0d observed %h expected %h", n, sel ? 3 : 1, o, e);
    end
    n++;
  endtask

  initial begin
    // reset with random ID contents
    step(1, 1, 5'(8), 5'(8), 5'(3), 1, C_LW, 0, $urandom, 0, 0);
    step(1, 1, 5'($urandom), 5'($urandom), 5'($urandom), 1, C_ADD, 0, $urandom, 0, 0);
    // pass-through
    step(0, 1, 5'd1, 5'd2, 5'd8, 1, C_ADD, 0, 32'h0000_00AA, 1, 0);
    // load-use, single bubble
    step(0, 1, 5'd3, 5'd8, 5'd0, 0, C_LW, 0, $urandom, 1, 0);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 0, $urandom, 0, 1);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 0, $urandom, 1, 0);
    // $zero destination never stalls
    step(0, 1, 5'd3, 5'd0, 5'd0, 0, C_LW, 0, $urandom, 1, 0);
    step(0, 1, 5'd0, 5'd0, 5'd2, 1, C_ADD, 0, $urandom, 1, 0);
    // rt match ignored when rt is not a source
    step(0, 1, 5'd3, 5'd9, 5'd0, 0, C_LW, 0, $urandom, 1, 0);
    step(0, 1, 5'd4, 5'd9, 5'd6, 0, C_ADD, 0, $urandom, 1, 0);
    // invalid ID instruction never stalls and yields ex_valid=0
    step(0, 1, 5'd3, 5'd10, 5'd0, 0, C_LW, 0, $urandom, 1, 0);
    step(0, 0, 5'd10, 5'd10, 5'd7, 1, C_ADD, 0, $urandom, 1, 0);
    // flush beats hazard, then flush alone
    step(0, 1, 5'd3, 5'd11, 5'd0, 0, C_LW, 0, $urandom, 1, 0);
    step(0, 1, 5'd11, 5'd4, 5'd12, 1, C_ADD, 1, $urandom, 0, 0);
    step(0, 1, 5'd11, 5'd4, 5'd12, 1, C_ADD, 0, $urandom, 1, 0);
    step(0, 1, 5'd1, 5'd2, 5'd13, 1, C_ADD, 1, $urandom, 0, 0);
    // three-bubble configuration
    sel = 1'b1;
    step(1, 1, 5'd1, 5'd2, 5'd3, 1, C_ADD, 0, $urandom, 0, 0);
    step(0, 1, 5'd3, 5'd8, 5'd0, 0, C_LW, 0, $urandom, 1, 0);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 0, $urandom, 0, 1);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 0, $urandom, 0, 1);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 0, $urandom, 0, 1);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 0, $urandom, 1, 0);
    // flush in the second stall cycle returns to RUN
    step(0, 1, 5'd3, 5'd8, 5'd0, 0, C_LW, 0, $urandom, 1, 0);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 0, $urandom, 0, 1);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 1, $urandom, 0, 0);
    step(0, 1, 5'd8, 5'd5, 5'd9, 1, C_ADD, 0, $urandom, 1, 0);
    // reset in the second stall cycle returns to RUN with nothing pending
    step(0, 1, 5'd3, 5'd8, 5'd0, 0, C_LW, 0, $urandom, 1, 0);
    step(0, 1, 5'd5, 5'd8, 5'd9, 1, C_ADD, 0, $urandom, 0, 1);
    step(1, 1, 5'd5, 5'd8, 5'd9, 1, C_ADD, 0, $urandom, 0, 0);
    step(0, 1, 5'd5, 5'd8, 5'd9, 1, C_ADD, 0, $urandom, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
